// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default bundle
// widths, bit positions inside the control bundle and the ALUOp encodings.
package pipe_pkg;

    localparam int CTRL_W_DEF = 8;
    localparam int DATA_W_DEF = 96;
    localparam int CNT_W_DEF  = 16;

    // Bit positions inside the control bundle
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP    = 0;   // lsb of the 2-bit ALUOp field
    localparam int CTRL_ALUOP_W  = 2;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,   // loads / stores: address add
        ALUOP_SUB   = 2'b01,   // branches: compare by subtract
        ALUOP_RTYPE = 2'b10,   // decode from funct field
        ALUOP_IMM   = 2'b11    // immediate arithmetic
    } aluop_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus control and data bundles.
// clear (bubble) has priority over load; otherwise the entry holds.
// Whenever the entry becomes invalid and CLR_CTRL is set, its control bits are
// zeroed in the flop, so a bubble never carries live control signals.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit CLR_CTRL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              clear,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    // Entry register: async reset to an empty, all-zero entry
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            if (CLR_CTRL) ctrl_q <= '0;
        end else if (load) begin
            valid_q <= valid_d;
            if (valid_d) begin
                ctrl_q <= ctrl_d;
                data_q <= data_d;
            end else if (CLR_CTRL) begin
                ctrl_q <= '0;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic inter-stage pipeline register with valid/ready handshake,
// flush-to-bubble and a saturating stall-cycle counter.
// Optional macro ELASTIC_PIPE_SKID_EN adds a second (skid) entry so that
// ready_o becomes a pure register; without it the stage has a single entry
// and ready_o depends combinationally on ready_i/stall_i.
//
// Handshake: a beat is accepted on a rising edge where valid_i & ready_o, and
// handed off on a rising edge where valid_o & ready_i & !stall_i. stall_i acts
// exactly like ready_i=0 on the output side. flush_i empties every entry at
// the edge (a beat accepted in that cycle is dropped) and wins over stall_i.
module elastic_pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit CLR_CTRL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              handoff;
    logic              accept;
    logic              main_load;
    logic              main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;

    assign handoff = valid_o & ready_i & ~stall_i;
    assign accept  = valid_i & ready_o;

`ifdef ELASTIC_PIPE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              main_free;
    logic              skid_load;
    logic              skid_valid_d;

    // Ready only reflects skid occupancy, so it is straight off a flop
    assign ready_o   = ~skid_valid;
    // Main can take a new beat when it is empty or its beat leaves this edge
    assign main_free = ~valid_o | handoff;

    // Steering: main refills from skid first (FIFO order), else from input;
    // skid drains into main, or catches a beat while main is held
    always_comb begin
        main_load    = main_free;
        main_valid_d = skid_valid | accept;
        main_ctrl_d  = skid_valid ? skid_ctrl : ctrl_i;
        main_data_d  = skid_valid ? skid_data : data_i;
        skid_load    = main_free ? skid_valid : accept;
        skid_valid_d = ~main_free;
    end

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_CTRL (CLR_CTRL)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (skid_load),
        .clear   (flush_i),
        .valid_d (skid_valid_d),
        .ctrl_d  (ctrl_i),
        .data_d  (data_i),
        .valid_q (skid_valid),
        .ctrl_q  (skid_ctrl),
        .data_q  (skid_data)
    );
`else
    // Single entry: room whenever empty or its beat leaves this edge
    assign ready_o = ~valid_o | (ready_i & ~stall_i);

    // Main entry updates on any accept or handoff; a handoff with no
    // accept loads a bubble
    always_comb begin
        main_load    = accept | handoff;
        main_valid_d = accept;
        main_ctrl_d  = ctrl_i;
        main_data_d  = data_i;
    end
`endif

    pipe_entry_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_CTRL (CLR_CTRL)
    ) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (main_load),
        .clear   (flush_i),
        .valid_d (main_valid_d),
        .ctrl_d  (main_ctrl_d),
        .data_d  (main_data_d),
        .valid_q (valid_o),
        .ctrl_q  (ctrl_o),
        .data_q  (data_o)
    );

    // Stall counter: one per edge with a waiting output beat, sticks at all-ones
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !(ready_i && !stall_i) && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Bench for elastic_pipe_stage. Runs the same checks with or without
// ELASTIC_PIPE_SKID_EN; only the skid/ready section differs between builds.
// A second instance with a 4-bit counter shares all inputs for saturation.
module tb_elastic_pipe_stage;

    localparam int CW = 8;
    localparam int DW = 96;
    localparam int NW = 16;
    localparam int SW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [CW-1:0] ctrl_i = '0;
    logic [DW-1:0] data_i = '0;

    logic          ready_o, valid_o;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] data_o;
    logic [NW-1:0] cnt_o;

    logic          ready_s, valid_s;
    logic [CW-1:0] ctrl_s;
    logic [DW-1:0] data_s;
    logic [SW-1:0] cnt_s;

    elastic_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW), .CLR_CTRL(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
        .ctrl_o(ctrl_o), .data_o(data_o), .stall_i(stall_i), .flush_i(flush_i),
        .stall_cnt_o(cnt_o)
    );

    elastic_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(SW), .CLR_CTRL(1'b1)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_s),
        .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_s), .ready_i(ready_i),
        .ctrl_o(ctrl_s), .data_o(data_s), .stall_i(stall_i), .flush_i(flush_i),
        .stall_cnt_o(cnt_s)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- counters and compare ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Stage contents as a FIFO of {ctrl, data}; head is what the output shows.
    logic [CW+DW-1:0] exp_q[$];
    int unsigned      m_cnt;
    int unsigned      m_cnt_s;

    function automatic bit exp_ready();
`ifdef ELASTIC_PIPE_SKID_EN
        return exp_q.size() < 2;
`else
        return (exp_q.size() == 0) || (ready_i && !stall_i);
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic model_edge(input bit rdy);
        bit go;
        go = (exp_q.size() > 0) && ready_i && !stall_i;
        if (exp_q.size() > 0 && !(ready_i && !stall_i)) begin
            if (m_cnt   < (1 << NW) - 1) m_cnt++;
            if (m_cnt_s < (1 << SW) - 1) m_cnt_s++;
        end
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (go) void'(exp_q.pop_front());
            if (valid_i && rdy) exp_q.push_back({ctrl_i, data_i});
        end
    endtask

    task automatic check_all();
        if (exp_q.size() > 0) begin
            chk("valid_o", 128'(valid_o), 128'(1'b1));
            chk("data_o",  128'(data_o),  128'(exp_q[0][DW-1:0]));
            chk("ctrl_o",  128'(ctrl_o),  128'(exp_q[0][CW+DW-1:DW]));
            chk("valid_s", 128'(valid_s), 128'(1'b1));
            chk("data_s",  128'(data_s),  128'(exp_q[0][DW-1:0]));
        end else begin
            chk("valid_o", 128'(valid_o), 128'(1'b0));
            chk("ctrl_o bubble", 128'(ctrl_o), 128'(0));
            chk("valid_s", 128'(valid_s), 128'(1'b0));
            chk("ctrl_s bubble", 128'(ctrl_s), 128'(0));
        end
        chk("stall_cnt_o", 128'(cnt_o), 128'(m_cnt));
        chk("stall_cnt_s", 128'(cnt_s), 128'(m_cnt_s));
        if (rst_i) begin
            chk("ready_o", 128'(ready_o), 128'(exp_ready()));
            chk("ready_s", 128'(ready_s), 128'(exp_ready()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic r, input logic s, input logic f,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
        valid_i = v; ready_i = r; stall_i = s; flush_i = f; ctrl_i = c; data_i = d;
    endtask

    // Called at a negedge; returns at a negedge with reset released
    task automatic reset_dut();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        model_clear();
    endtask

    // Drive at negedge, step one rising edge, return 2 time units later
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v, r, s, f;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic [NW-1:0] ecnt;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic v, input logic r, input logic s, input logic f,
                                input logic [CW-1:0] c, input logic [DW-1:0] d,
                                input logic ev, input logic [CW-1:0] ec,
                                input logic [DW-1:0] ed, input logic [NW-1:0] ecnt);
        vec_t t;
        t.v = v; t.r = r; t.s = s; t.f = f; t.c = c; t.d = d;
        t.ev = ev; t.ec = ec; t.ed = ed; t.ecnt = ecnt;
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit er;

        // streaming 1..4, no gaps
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 96'h1,  1'b1, 8'h01, 96'h1,  16'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 96'h2,  1'b1, 8'h02, 96'h2,  16'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 96'h3,  1'b1, 8'h03, 96'h3,  16'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 96'h4,  1'b1, 8'h04, 96'h4,  16'd0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 96'h0,  1'b0, 8'h00, 96'h0,  16'd0);
        // stall holds 0xA5 for three edges, then hands it off once
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 96'hA5, 1'b1, 8'h5A, 96'hA5, 16'd0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 96'h0,  1'b1, 8'h5A, 96'hA5, 16'd1);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 96'h0,  1'b1, 8'h5A, 96'hA5, 16'd2);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 96'h0,  1'b1, 8'h5A, 96'hA5, 16'd3);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 96'h0,  1'b0, 8'h00, 96'h0,  16'd3);
        // flush with ctrl=0xFF at the output and an incoming beat
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 96'h11, 1'b1, 8'hFF, 96'h11, 16'd3);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 96'h22, 1'b0, 8'h00, 96'h0,  16'd3);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 96'h0,  1'b0, 8'h00, 96'h0,  16'd3);
        // downstream not ready counts as a stall cycle
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 96'h33, 1'b1, 8'hC3, 96'h33, 16'd3);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 96'h0,  1'b1, 8'hC3, 96'h33, 16'd4);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 96'h0,  1'b0, 8'h00, 96'h0,  16'd4);
        // flush wins over stall; the stalled edge still counts
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 96'h44, 1'b1, 8'h81, 96'h44, 16'd4);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 96'h0,  1'b0, 8'h00, 96'h0,  16'd5);

        @(negedge clk_i);
        reset_dut();
        chk("reset valid_o", 128'(valid_o), 128'(1'b0));
        chk("reset ready_o", 128'(ready_o), 128'(1'b1));
        chk("reset cnt",     128'(cnt_o),   128'(0));

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].d);
            step();
            chk($sformatf("tbl%0d valid_o", i), 128'(valid_o), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d ctrl_o", i),  128'(ctrl_o),  128'(tbl[i].ec));
            if (tbl[i].ev)
                chk($sformatf("tbl%0d data_o", i), 128'(data_o), 128'(tbl[i].ed));
            chk($sformatf("tbl%0d cnt", i),   128'(cnt_o), 128'(tbl[i].ecnt));
            chk($sformatf("tbl%0d cnt_s", i), 128'(cnt_s), 128'(tbl[i].ecnt[SW-1:0]));
            @(negedge clk_i);
        end

        // ---- async reset mid-stream ----
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 96'hBEEF);
        step();
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        step();
        @(negedge clk_i);
        chk("pre-reset valid_o", 128'(valid_o), 128'(1'b1));
        chk("pre-reset cnt",     128'(cnt_o),   128'(2));
        rst_i = 1'b0;
        #1;
        chk("async reset valid_o", 128'(valid_o), 128'(1'b0));
        chk("async reset data_o",  128'(data_o),  128'(0));
        chk("async reset ctrl_o",  128'(ctrl_o),  128'(0));
        chk("async reset cnt",     128'(cnt_o),   128'(0));
        chk("async reset cnt_s",   128'(cnt_s),   128'(0));
        @(negedge clk_i);
        rst_i = 1'b1;
        model_clear();
        #1;
        chk("post-reset ready_o", 128'(ready_o), 128'(1'b1));

        // ---- skid / ready behaviour ----
        reset_dut();
`ifdef ELASTIC_PIPE_SKID_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 96'h7);
        step();
        chk("skid ready after 1st", 128'(ready_o), 128'(1'b1));
        @(negedge clk_i);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 96'h8);
        step();
        chk("skid ready after 2nd", 128'(ready_o), 128'(1'b0));
        chk("skid head 7",          128'(data_o),  128'(96'h7));
        @(negedge clk_i);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("skid ready registered", 128'(ready_o), 128'(1'b0));
        step();
        chk("skid second out valid", 128'(valid_o), 128'(1'b1));
        chk("skid second out 8",     128'(data_o),  128'(96'h8));
        chk("skid ready reopens",    128'(ready_o), 128'(1'b1));
        step();
        chk("skid drained", 128'(valid_o), 128'(1'b0));
        @(negedge clk_i);
`else
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 96'h7);
        step();
        @(negedge clk_i);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h08, 96'h8);
        #1;
        chk("full ready_o low",  128'(ready_o), 128'(1'b0));
        ready_i = 1'b1;
        #1;
        chk("comb ready_o high", 128'(ready_o), 128'(1'b1));
        step();
        chk("replace valid", 128'(valid_o), 128'(1'b1));
        chk("replace data 8", 128'(data_o), 128'(96'h8));
        @(negedge clk_i);
`endif

        // ---- counter saturation ----
        reset_dut();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h09, 96'h9);
        step();
        @(negedge clk_i);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat cnt_s k=%0d", k), 128'(cnt_s), 128'((k > 15) ? 15 : k));
            chk($sformatf("sat cnt k=%0d", k),   128'(cnt_o), 128'(k));
        end
        chk("sat still valid", 128'(valid_s), 128'(1'b1));
        chk("sat data held",   128'(data_s),  128'(96'h9));
        @(negedge clk_i);

        // ---- randomized run against the model ----
        reset_dut();
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) @(negedge clk_i);
            if (!rst_i) rst_i = 1'b1;
            drive(1'($urandom_range(3) != 0), 1'($urandom_range(9) < 6),
                  1'($urandom_range(6) == 0), 1'($urandom_range(19) == 0),
                  8'($urandom), {$urandom, $urandom, $urandom});
            if ($urandom_range(199) == 0) rst_i = 1'b0;
            #1;
            if (!rst_i) begin
                model_clear();
                chk("rand reset data_o", 128'(data_o), 128'(0));
            end
            check_all();
            er = exp_ready();
            @(posedge clk_i);
            if (rst_i) model_edge(er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
